prgrm_sequencer: RTL
====================

PRGRM_SEQUENCER -- requirements
Module: prgrm_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program-counter width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Run, input, 1, which enables instruction sequencing.
REQ-006 SHALL have port Stall, input, 1, which holds the sequencer in DECODE/EXECUTE/WRITEBACK.
REQ-007 SHALL have port Instrn_In, input, 32, the fetched instruction word.
REQ-008 SHALL have port Instrn_Vld, input, 1; Instrn_In is valid and the fetch is complete when high.
REQ-009 SHALL have ports Incrmnt_PC, Ld_Brnch_Addr and Ld_Rtn_Addr, inputs, 1 each, program-decode results.
REQ-010 SHALL have port CurrentState, output, 3, the sequencer state code.
REQ-011 SHALL have port Crnt_Instrn, output, 32, the latched current instruction.
REQ-012 SHALL have port PC, output, PC_WIDTH, the program counter.
REQ-013 SHALL have port Fetch_Req, output, 1, the instruction-fetch request.
REQ-014 SHALL have ports Stack_Ovf and Stack_Unf, outputs, 1 each, sticky stack error flags.

Function
REQ-015 SHALL encode states IDLE=000, FETCH=001, LOAD=010, DECODE=011, EXECUTE=100, WRITEBACK=101; codes 110/111 SHALL go to IDLE on the next edge.
REQ-016 SHALL transition IDLE->FETCH when Run=1, and otherwise stay in IDLE.
REQ-017 SHALL drive Fetch_Req=1 only in FETCH and SHALL stay in FETCH until Instrn_Vld=1, then go to LOAD.
REQ-018 SHALL capture Instrn_In into Crnt_Instrn on the FETCH edge where Instrn_Vld=1, and SHALL ignore Instrn_Vld in every other state.
REQ-019 SHALL sequence LOAD->DECODE unconditionally; DECODE->EXECUTE, EXECUTE->WRITEBACK and WRITEBACK->next SHALL each advance only when Stall=0.
REQ-020 SHALL leave WRITEBACK for FETCH when Run=1 and for IDLE when Run=0; Run falling mid-instruction SHALL NOT abort that instruction.
REQ-021 SHALL give a minimum period of 5 cycles per instruction, measured from the Instrn_Vld edge to the next FETCH entry.
REQ-022 SHALL update PC only on the edge leaving EXECUTE (Stall=0), with priority Ld_Rtn_Addr > Ld_Brnch_Addr > Incrmnt_PC > hold.
REQ-023 SHALL load PC from Crnt_Instrn[PC_WIDTH-1:0] on Ld_Brnch_Addr.
REQ-024 SHALL also push PC+1 onto the stack on Ld_Brnch_Addr when Crnt_Instrn[28]=1 (call).
REQ-025 SHALL pop the stack top into PC on Ld_Rtn_Addr.
REQ-026 SHALL compute PC+1 modulo 2**PC_WIDTH, so all-ones wraps to 0.
REQ-027 SHALL, on a push with the stack full, discard the push, set Stack_Ovf, and still load the branch target.
REQ-028 SHALL, on a pop with the stack empty, load PC+1 and set Stack_Unf.
REQ-029 SHALL keep Stack_Ovf/Stack_Unf set until reset.
REQ-030 SHALL leave the stack contents unchanged when Ld_Rtn_Addr and Ld_Brnch_Addr are asserted together; only the pop occurs.

Reset
REQ-031 SHALL, with Reset_N=0, asynchronously force CurrentState=IDLE, PC=0, Crnt_Instrn=0, Fetch_Req=0, stack pointer=0, Stack_Ovf=0 and Stack_Unf=0.
REQ-032 SHALL treat reset in any state, including mid-fetch, as abandoning the instruction, with no PC or stack update.
REQ-033 SHALL remove reset synchronously; the first state change is possible on the first edge after Reset_N rises.

Structure
REQ-034 SHALL place the state codes and the instruction bit positions (RET=27, CALL=28, JMP=29) in shared package prgrm_seq_pkg.
REQ-035 SHALL implement the return-address stack as sub-module rtn_addr_stack, with push/pop/full/empty, depth STACK_DEPTH and width PC_WIDTH.

Verification
REQ-036 SHALL verify that reset, then Run=1 and Instrn_Vld=1 after 2 FETCH cycles with Incrmnt_PC=1, sets PC 0->1 on leaving EXECUTE and shows CurrentState 001,001,001,010,011,100,101,001.
REQ-037 SHALL verify that a call (Crnt_Instrn[28]=1, bits[7:0]=0x40, Ld_Brnch_Addr=1) at PC=0x05 gives PC=0x40 with stack top 0x06, and that a later Ld_Rtn_Addr gives PC=0x06.
REQ-038 SHALL verify that five calls with STACK_DEPTH=4 set Stack_Ovf on the fifth, with PC equal to the fifth target, and that four returns restore the first four return addresses.
REQ-039 SHALL verify that Ld_Rtn_Addr with an empty stack at PC=0xFF gives PC=0x00 and Stack_Unf=1.
REQ-040 SHALL verify that Stall=1 for 3 cycles in EXECUTE holds CurrentState=100 and PC, and that PC updates once after Stall falls.
REQ-041 SHALL verify that Reset_N pulsed low in DECODE returns the block to IDLE immediately with PC=0, and that Run=0 during EXECUTE ends in IDLE after WRITEBACK.

Source files
------------

// File: rtl/prgrm_seq_pkg.sv
// Shared definitions for the program sequencer: state codes and the
// instruction bit positions that the sequencer and decode logic agree on.
package prgrm_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_FETCH     = 3'b001,
        ST_LOAD      = 3'b010,
        ST_DECODE    = 3'b011,
        ST_EXECUTE   = 3'b100,
        ST_WRITEBACK = 3'b101
    } seq_state_t;

    localparam int RET_BIT  = 27;
    localparam int CALL_BIT = 28;
    localparam int JMP_BIT  = 29;

endpackage

// File: rtl/rtn_addr_stack.sv
// Return-address LIFO. The top entry is readable combinationally so a
// return can load it into the PC on the same edge that pops it.
module rtn_addr_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp_reg;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // sp_reg counts entries, so the top lives one below it
    assign wr_idx = IDX_W'(sp_reg);
    assign rd_idx = IDX_W'(sp_reg - PTR_W'(1));
    assign full   = (sp_reg == PTR_W'(DEPTH));
    assign empty  = (sp_reg == '0);
    assign top    = mem[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg <= '0;
        end else if (push && !full) begin
            sp_reg <= sp_reg + PTR_W'(1);
        end else if (pop && !empty) begin
            sp_reg <= sp_reg - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/prgrm_sequencer.sv
// Instruction sequencer: fetch/load/decode/execute/writeback FSM with a
// program counter and a return-address stack for call/return.
module prgrm_sequencer
    import prgrm_seq_pkg::*;
#(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Reset_N,
    input  logic                Run,
    input  logic                Stall,
    input  logic [31:0]         Instrn_In,
    input  logic                Instrn_Vld,
    input  logic                Incrmnt_PC,
    input  logic                Ld_Brnch_Addr,
    input  logic                Ld_Rtn_Addr,
    output logic [2:0]          CurrentState,
    output logic [31:0]         Crnt_Instrn,
    output logic [PC_WIDTH-1:0] PC,
    output logic                Fetch_Req,
    output logic                Stack_Ovf,
    output logic                Stack_Unf
);

    seq_state_t          state_reg, state_next;
    logic [31:0]         instr_reg;
    logic [PC_WIDTH-1:0] pc_reg, pc_next, pc_inc;
    logic                ovf_reg, ovf_next;
    logic                unf_reg, unf_next;
    logic                push, pop;
    logic [PC_WIDTH-1:0] stack_top;
    logic                stack_full, stack_empty;
    logic                exec_done;

    assign pc_inc    = pc_reg + PC_WIDTH'(1);
    assign exec_done = (state_reg == ST_EXECUTE) && !Stall;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (Run) state_next = ST_FETCH;
            ST_FETCH:     if (Instrn_Vld) state_next = ST_LOAD;
            ST_LOAD:      state_next = ST_DECODE;
            ST_DECODE:    if (!Stall) state_next = ST_EXECUTE;
            ST_EXECUTE:   if (!Stall) state_next = ST_WRITEBACK;
            ST_WRITEBACK: if (!Stall) state_next = Run ? ST_FETCH : ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Return beats branch beats increment; a simultaneous branch is ignored
    always_comb begin
        pc_next  = pc_reg;
        ovf_next = ovf_reg;
        unf_next = unf_reg;
        push     = 1'b0;
        pop      = 1'b0;
        if (exec_done) begin
            if (Ld_Rtn_Addr) begin
                if (stack_empty) begin
                    pc_next  = pc_inc;
                    unf_next = 1'b1;
                end else begin
                    pc_next = stack_top;
                    pop     = 1'b1;
                end
            end else if (Ld_Brnch_Addr) begin
                pc_next = instr_reg[PC_WIDTH-1:0];
                if (instr_reg[CALL_BIT]) begin
                    if (stack_full) ovf_next = 1'b1;
                    else            push     = 1'b1;
                end
            end else if (Incrmnt_PC) begin
                pc_next = pc_inc;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_reg <= ST_IDLE;
            instr_reg <= '0;
            pc_reg    <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
            if (state_reg == ST_FETCH && Instrn_Vld) begin
                instr_reg <= Instrn_In;
            end
        end
    end

    rtn_addr_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_stack (
        .clk       (Clk),
        .rst_n     (Reset_N),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign CurrentState = state_reg;
    assign Crnt_Instrn  = instr_reg;
    assign PC           = pc_reg;
    assign Fetch_Req    = (state_reg == ST_FETCH);
    assign Stack_Ovf    = ovf_reg;
    assign Stack_Unf    = unf_reg;

endmodule
